// File: rtl/hamming_secded_decoder_pkg.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder_pkg
// Shared definitions for the Hamming SECDED decoder and its syndrome block:
//   - code_w()          : codeword width; one extra overall-parity bit when
//                         HAMMING_SECDED_EN is defined
//   - par_w_ok()        : parity width check (2^PAR_W >= DATA_W+PAR_W+1)
//   - is_pow2()         : true for Hamming parity positions
//   - pos_to_data_idx() : Hamming position -> data bit index
//   - pos_bit()         : bit j of a Hamming position
//   - status_e          : decode status; bit 0 = corrected, bit 1 = uncorrectable
// Optional feature macro: HAMMING_SECDED_EN
// -----------------------------------------------------------------------------
package hamming_secded_decoder_pkg;

    typedef enum logic [1:0] {
        ST_CLEAN         = 2'b00,
        ST_CORRECTED     = 2'b01,
        ST_UNCORRECTABLE = 2'b10
    } status_e;

    function automatic int code_w(input int data_w, input int par_w);
`ifdef HAMMING_SECDED_EN
        return data_w + par_w + 1;
`else
        return data_w + par_w;
`endif
    endfunction

    function automatic bit is_pow2(input int unsigned x);
        return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
    endfunction

    function automatic bit par_w_ok(input int data_w, input int par_w);
        return (64'd1 << par_w) >= 64'(data_w + par_w + 1);
    endfunction

    // Data positions are the non-power-of-two positions in ascending order,
    // so the index is pos-1 minus the number of parity positions <= pos.
    function automatic int pos_to_data_idx(input int pos);
        int n_par;
        n_par = 0;
        for (int j = 0; j < 31; j++) begin
            n_par = n_par + (((32'd1 << j) <= 32'(pos)) ? 1 : 0);
        end
        return pos - 1 - n_par;
    endfunction

    function automatic logic pos_bit(input int pos, input int j);
        return logic'((32'(pos) >> j) & 32'd1);
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder_if
// Valid/ready input and output channels of the decoder.
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : decoder side (drives in_ready, out_*)
// Codeword width follows HAMMING_SECDED_EN through code_w().
// -----------------------------------------------------------------------------
interface hamming_secded_decoder_if #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4
);
    import hamming_secded_decoder_pkg::*;

    localparam int CODE_W = code_w(DATA_W, PAR_W);

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              out_corrected;
    logic              out_uncorrectable;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable
    );

endinterface

// File: rtl/hamming_secded_decoder_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Purely combinational syndrome / overall-parity generator.
//   code_i : received codeword (CODE_W bits, bit i = Hamming position i+1)
//   syn_o  : Hamming syndrome over the DATA_W+PAR_W Hamming bits
//   par_o  : XOR of every codeword bit (overall parity check)
// Codeword width follows HAMMING_SECDED_EN through code_w().
// -----------------------------------------------------------------------------
module hamming_syndrome
    import hamming_secded_decoder_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int PAR_W  = 4,
    localparam int CODE_W = code_w(DATA_W, PAR_W)
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  syn_o,
    output logic              par_o
);

    // Syndrome bit j collects every Hamming bit whose position has bit j set.
    always_comb begin
        syn_o = '0;
        for (int i = 0; i < DATA_W + PAR_W; i++) begin
            for (int j = 0; j < PAR_W; j++) begin
                syn_o[j] = syn_o[j] ^ (code_i[i] & pos_bit(i + 1, j));
            end
        end
    end

    assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder
// Two-stage pipelined Hamming decoder with saturating error counters.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : in_valid/in_ready/in_code, out_valid/out_ready/out_data,
//                 out_syndrome, out_corrected, out_uncorrectable
//   clr_cnt     : synchronous clear of both counters (wins over increment)
//   corr_cnt    : saturating count of corrected words delivered
//   uncorr_cnt  : saturating count of uncorrectable words delivered
// Stage 1 registers code, syndrome and overall parity; stage 2 registers the
// corrected data and status. Optional feature macro: HAMMING_SECDED_EN
// (adds an overall parity bit and double-error detection).
// -----------------------------------------------------------------------------
module hamming_secded_decoder
    import hamming_secded_decoder_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hamming_secded_decoder_if.slave  bus,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);

    localparam int CODE_W = code_w(DATA_W, PAR_W);
    localparam int N      = DATA_W + PAR_W;

    if (!par_w_ok(DATA_W, PAR_W)) begin : g_par_w_check
        $fatal(1, "hamming_secded_decoder: PAR_W too small for DATA_W");
    end

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [PAR_W-1:0]  s2_syn_q, s2_syn_d;
    status_e           s2_status_q, s2_status_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic [PAR_W-1:0]  syn_s;
    logic              par_s;
    logic              s1_adv_s, s2_adv_s, out_fire_s, in_range_s, flip_s;
    status_e           status_s;
    logic [CODE_W-1:0] fixed_s;
    logic [DATA_W-1:0] data_s;
    logic              unused_s;

    hamming_syndrome #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W)
    ) u_syndrome (
        .code_i (bus.in_code),
        .syn_o  (syn_s),
        .par_o  (par_s)
    );

    assign s2_adv_s     = !s2_valid_q || bus.out_ready;
    assign s1_adv_s     = !s1_valid_q || s2_adv_s;
    assign bus.in_ready = rst_n && s1_adv_s;
    assign out_fire_s   = s2_valid_q && bus.out_ready;
    assign in_range_s   = (s1_syn_q != '0) && (32'(s1_syn_q) <= 32'(N));

    // Stage 1 loads whenever it is empty or drains into stage 2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_code_d = bus.in_code;
                s1_syn_d  = syn_s;
                s1_par_d  = par_s;
            end else begin
                s1_code_d = s1_code_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Classify the stage-1 word and decide whether a bit must be flipped.
    always_comb begin
        status_s = ST_CLEAN;
        flip_s   = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                // only the overall parity bit is wrong: data already good
                status_s = ST_CORRECTED;
            end else if (in_range_s) begin
                status_s = ST_CORRECTED;
                flip_s   = 1'b1;
            end else begin
                status_s = ST_UNCORRECTABLE;
            end
        end else if (s1_syn_q != '0) begin
            // even overall parity with nonzero syndrome: double error
            status_s = ST_UNCORRECTABLE;
        end else begin
            status_s = ST_CLEAN;
        end
`else
        if (in_range_s) begin
            status_s = ST_CORRECTED;
            flip_s   = 1'b1;
        end else if (s1_syn_q != '0) begin
            status_s = ST_UNCORRECTABLE;
        end else begin
            status_s = ST_CLEAN;
        end
`endif
    end

    // Flip the erroneous position and gather the data positions.
    always_comb begin
        if (flip_s) begin
            fixed_s = s1_code_q ^ (CODE_W'(1'b1) << (s1_syn_q - PAR_W'(1'b1)));
        end else begin
            fixed_s = s1_code_q;
        end
        data_s = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!is_pow2(pos)) begin
                data_s[pos_to_data_idx(pos)] = fixed_s[pos - 1];
            end else begin
                // parity position: carries no data
            end
        end
    end

`ifdef HAMMING_SECDED_EN
    assign unused_s = ^fixed_s;
`else
    assign unused_s = (^fixed_s) ^ s1_par_q;
`endif

    // Stage 2 advances when empty or when the consumer takes the result.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_syn_d    = s2_syn_q;
        s2_status_d = s2_status_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = data_s;
                s2_syn_d    = s1_syn_q;
                s2_status_d = status_s;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Saturating counters bumped on the output handshake; clear has priority.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (out_fire_s && (s2_status_q == ST_CORRECTED) && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1'b1);
            end else begin
                corr_cnt_d = corr_cnt_q;
            end
            if (out_fire_s && (s2_status_q == ST_UNCORRECTABLE) && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1'b1);
            end else begin
                uncorr_cnt_d = uncorr_cnt_q;
            end
        end
    end

    // Pipeline and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_syn_q     <= '0;
            s2_status_q  <= ST_CLEAN;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_syn_q     <= s2_syn_d;
            s2_status_q  <= s2_status_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.out_valid         = s2_valid_q;
    assign bus.out_data          = s2_data_q;
    assign bus.out_syndrome      = s2_syn_q;
    assign bus.out_corrected     = s2_status_q[0];
    assign bus.out_uncorrectable = s2_status_q[1];
    assign corr_cnt              = corr_cnt_q;
    assign uncorr_cnt            = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_decoder
// Directed and random stimulus against a behavioural decoder model. Two
// decoders see identical inputs: one with 16-bit counters, one with 2-bit
// counters to exercise saturation. Honours HAMMING_SECDED_EN.
// -----------------------------------------------------------------------------
module tb_hamming_secded_decoder;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 4;
    localparam int N      = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W = N + 1;
    localparam bit SECDED = 1'b1;
`else
    localparam int CODE_W = N;
    localparam bit SECDED = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  syn;
        logic              corr;
        logic              uncorr;
        int                age;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_cnt;
    logic [15:0] corr_a, uncorr_a;
    logic [1:0]  corr_b, uncorr_b;

    exp_t q[$];
    int   corr_tot   = 0;
    int   uncorr_tot = 0;
    int   checks     = 0;
    int   errors     = 0;
    logic last_in_fire = 1'b0;

    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.DATA_W(DATA_W), .PAR_W(PAR_W)) bus_a ();
    hamming_secded_decoder_if #(.DATA_W(DATA_W), .PAR_W(PAR_W)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_code   = bus_a.in_code;
    assign bus_b.out_ready = bus_a.out_ready;

    hamming_secded_decoder #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_cnt(clr_cnt),
        .corr_cnt(corr_a), .uncorr_cnt(uncorr_a)
    );

    hamming_secded_decoder #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_cnt(clr_cnt),
        .corr_cnt(corr_b), .uncorr_cnt(uncorr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // Encoder: data into non-power-of-two positions, parity bits cancel the syndrome.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c = '0;
        int k = 0;
        int s = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                if (d[k]) s = s ^ pos;
                k++;
            end
        end
        for (int j = 0; j < PAR_W; j++) c[(1 << j) - 1] = s[j];
        if (SECDED) c[CODE_W-1] = ^c[N-1:0];
        return c;
    endfunction

    // Reference decode: syndrome as XOR of the positions of all set bits.
    function automatic exp_t ref_decode(input logic [CODE_W-1:0] c);
        exp_t e;
        int s = 0;
        int p = 0;
        int flip = 0;
        int k = 0;
        logic [CODE_W-1:0] f;
        for (int i = 0; i < N; i++) if (c[i]) s = s ^ (i + 1);
        for (int i = 0; i < CODE_W; i++) p = p ^ int'(c[i]);
        e.corr = 1'b0;
        e.uncorr = 1'b0;
        if (SECDED && p == 0 && s != 0) e.uncorr = 1'b1;
        else if (SECDED && p == 1 && s == 0) e.corr = 1'b1;
        else if (s != 0 && s <= N) begin e.corr = 1'b1; flip = s; end
        else if (s != 0) e.uncorr = 1'b1;
        f = c;
        if (flip != 0) f[flip-1] = ~f[flip-1];
        e.data = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                e.data[k] = f[pos-1];
                k++;
            end
        end
        e.syn = PAR_W'(s);
        e.age = 0;
        return e;
    endfunction

    function automatic logic [CODE_W-1:0] corrupt(input logic [CODE_W-1:0] c, input int nb);
        int b1 = int'($urandom_range(0, CODE_W - 1));
        int b2 = (b1 + 1 + int'($urandom_range(0, CODE_W - 2))) % CODE_W;
        if (nb >= 1) c[b1] = ~c[b1];
        if (nb >= 2) c[b2] = ~c[b2];
        return c;
    endfunction

    // One clock: check at the falling edge, update the model, then advance.
    task automatic step();
        logic in_fire;
        logic out_fire;
        logic exp_ov;
        @(negedge clk);
        foreach (q[k]) q[k].age++;
        in_fire  = 1'b0;
        out_fire = 1'b0;
        exp_ov   = 1'b0;
        if (!rst_n) begin
            chk("in_ready_in_reset", bus_a.in_ready, 32'd0);
        end else begin
            chk("in_ready", bus_a.in_ready, 32'((q.size() < 2) || bus_a.out_ready));
            exp_ov = (q.size() > 0) && (q[0].age >= 2);
            chk("out_valid", bus_a.out_valid, 32'(exp_ov));
            chk("out_valid_b", bus_b.out_valid, 32'(exp_ov));
            if (exp_ov) begin
                chk("out_data", bus_a.out_data, q[0].data);
                chk("out_data_b", bus_b.out_data, q[0].data);
                chk("out_syndrome", bus_a.out_syndrome, q[0].syn);
                chk("out_corrected", bus_a.out_corrected, q[0].corr);
                chk("out_uncorrectable", bus_a.out_uncorrectable, q[0].uncorr);
            end
            chk("corr_cnt", corr_a, sat(corr_tot, 16));
            chk("uncorr_cnt", uncorr_a, sat(uncorr_tot, 16));
            chk("corr_cnt_sat", corr_b, sat(corr_tot, 2));
            chk("uncorr_cnt_sat", uncorr_b, sat(uncorr_tot, 2));
            in_fire  = bus_a.in_valid && bus_a.in_ready;
            out_fire = bus_a.out_valid && bus_a.out_ready;
        end
        if (out_fire && exp_ov) begin
            if (q[0].corr) corr_tot++;
            if (q[0].uncorr) uncorr_tot++;
            void'(q.pop_front());
        end
        if (clr_cnt) begin
            corr_tot = 0;
            uncorr_tot = 0;
        end
        if (in_fire) q.push_back(ref_decode(bus_a.in_code));
        last_in_fire = in_fire;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            corr_tot = 0;
            uncorr_tot = 0;
        end
        #1;
    endtask

    task automatic send(input logic [CODE_W-1:0] code);
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = code;
        step();
        for (int c = 0; c < 10 && !last_in_fire; c++) step();
        chk("send_timeout", 32'(last_in_fire), 32'd1);
    endtask

    task automatic drain();
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) step();
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    initial begin
        logic [CODE_W-1:0] zero_cw;
        logic [CODE_W-1:0] words[4];
        int idx;

        rst_n = 1'b0;
        clr_cnt = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_code = '0;
        bus_a.out_ready = 1'b0;
        zero_cw = encode('0);
        for (int c = 0; c < 3; c++) step();
        chk("rst_out_valid", bus_a.out_valid, 32'd0);
        chk("rst_out_data", bus_a.out_data, 32'd0);
        chk("rst_syndrome", bus_a.out_syndrome, 32'd0);
        chk("rst_flags", {bus_a.out_corrected, bus_a.out_uncorrectable}, 32'd0);
        chk("rst_counters", {corr_a, uncorr_a}, 32'd0);
        rst_n = 1'b1;

        // Clean words, latency 2
        bus_a.out_ready = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_code = encode(11'h7FF);
        step();
        chk("lat_not_yet", bus_a.out_valid, 32'd0);
        bus_a.in_code = zero_cw;
        step();
        chk("lat_first_valid", bus_a.out_valid, 32'd1);
        chk("lat_first_data", bus_a.out_data, 32'h7FF);
        chk("lat_first_syn", bus_a.out_syndrome, 32'd0);
        bus_a.in_valid = 1'b0;
        step();
        chk("second_data", bus_a.out_data, 32'h000);
        drain();

        // Single error at position 3, two errors at positions 1/2, top bit flipped
        send(zero_cw ^ CODE_W'(4));
        send(zero_cw ^ CODE_W'(3));
        send(zero_cw ^ (CODE_W'(1) << (CODE_W - 1)));
        drain();

        // Backpressure: 4 back-to-back words with the consumer stalled 3 cycles
        for (int i = 0; i < 4; i++) words[i] = encode(DATA_W'($urandom));
        idx = 0;
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_code = words[0];
        for (int c = 0; c < 3; c++) begin
            step();
            if (last_in_fire) begin
                idx++;
                bus_a.in_code = words[idx];
            end
        end
        chk("bp_accepted", idx, 32'd2);
        bus_a.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step();
            if (last_in_fire) begin
                idx++;
                if (idx < 4) bus_a.in_code = words[idx];
            end
        end
        chk("bp_all_sent", idx, 32'd4);
        drain();

        // Counters: 5 corrections, then clear coincident with a sixth
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(corrupt(encode(DATA_W'($urandom)), 1));
        drain();
        chk("corr_cnt_five", corr_a, 32'd5);
        chk("corr_cnt_saturated", corr_b, 32'd3);
        bus_a.out_ready = 1'b0;
        send(zero_cw ^ CODE_W'(16));
        bus_a.in_valid = 1'b0;
        for (int c = 0; c < 5 && !bus_a.out_valid; c++) step();
        chk("clr_word_ready", bus_a.out_valid, 32'd1);
        bus_a.out_ready = 1'b1;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_wins", {corr_a, 14'd0, corr_b}, 32'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (!bus_a.in_valid || last_in_fire) begin
                bus_a.in_valid = ($urandom_range(0, 3) != 0);
                bus_a.in_code = corrupt(encode(DATA_W'($urandom)), int'($urandom_range(0, 2)));
            end
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt = ($urandom_range(0, 29) == 0);
            step();
        end
        clr_cnt = 1'b0;
        drain();

        // Reset with both stages full
        bus_a.out_ready = 1'b0;
        send(encode(11'h155));
        send(encode(11'h2AA));
        bus_a.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_flush_valid", bus_a.out_valid, 32'd0);
        bus_a.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("rst_flush_counters", {corr_a, uncorr_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Parametrised, pipelined Hamming decoder that sits on the receive side of a link carrying codewords from the team's Hamming encoders. It accepts one codeword per cycle over a valid/ready handshake and computes the syndrome. It corrects single-bit errors, optionally detects double-bit errors, and returns the data bits with status flags. Saturating error counters give link-health telemetry.

## Interface
- DATA_W, 11, data bits per word.
- PAR_W, 4, Hamming parity bits; 2^PAR_W ≥ DATA_W+PAR_W+1 is required and is checked at elaboration.
- CNT_W, 16, error-counter width.
- CODE_W (derived, not overridable): DATA_W+PAR_W, plus 1 when HAMMING_SECDED_EN is defined.
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  decoder accepts in_code this cycle.
- in_code  in  CODE_W  received codeword.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  PAR_W  raw syndrome.
- out_corrected  out  1  a single error was corrected.
- out_uncorrectable  out  1  an error was detected but not corrected.
- clr_cnt  in  1  synchronous counter clear.
- corr_cnt  out  CNT_W  count of corrected words.
- uncorr_cnt  out  CNT_W  count of uncorrectable words.

## Operation
- **Layout.** Bit index i holds Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order (data[0] is at position 3).
  - With SECDED, index CODE_W-1 holds overall parity: the XOR of all other bits.
- **Syndrome.** s[j] = XOR of in_code[i] over i < DATA_W+PAR_W where bit j of (i+1) is set. Even parity.
- **Stage 1** registers the code, s, and the overall parity p (the XOR of all CODE_W bits).
- **Stage 2** flips position s when a correction applies, extracts the data, and registers the data and flags.
- **Classification without SECDED:**
  - s=0: clean.
  - 0 < s ≤ DATA_W+PAR_W: corrected.
  - s > DATA_W+PAR_W: uncorrectable, raw data passed through.
- **Classification with SECDED:**
  - s=0, p=0: clean.
  - s=0, p=1: the overall parity bit is in error; corrected, data unchanged.
  - s≠0, p=1: single error; corrected, or uncorrectable if s is out of range.
  - s≠0, p=0: double error; uncorrectable, raw data passed through.
- out_corrected and out_uncorrectable are never both 1.
- **Counters.**
  - A counter increments on the output handshake (out_valid && out_ready) when the matching flag is set.
  - Counters saturate at all-ones.
  - clr_cnt zeroes both counters and wins over a same-cycle increment.

## Timing
- Latency is 2 cycles from the input handshake to out_valid, with no stall. Throughput is 1 word per cycle.
- Handshake:
  - The stage-2 register advances when it is empty or out_ready=1.
  - in_ready = !s1_valid || stage-2 advance (combinational).
  - No bubbles and no loss under backpressure; order is preserved.
- out_* outputs are held stable while out_valid=1 and out_ready=0.
- Reset values: in_ready=0 during reset, 1 in the first cycle after reset. out_valid=0. out_data, out_syndrome, the flags and both counters are 0.
- Reset mid-operation discards both stages. No partial word is emitted.

## Configuration
- HAMMING_SECDED_EN:
  - Defined: CODE_W = DATA_W+PAR_W+1, overall parity is checked, double errors are detected.
  - Undefined: CODE_W = DATA_W+PAR_W, any in-range nonzero syndrome is treated as a single error. uncorr_cnt counts only out-of-range syndromes.

## Structure
- Shared package/header holds:
  - position-to-data-index mapping function;
  - is_pow2 helper;
  - parity-width check;
  - status encoding constants.
- One sub-module, hamming_syndrome, is natural: purely combinational, parametrised by DATA_W and PAR_W, outputs s and p. It is reusable by a future encoder check.
- The top level holds the two pipeline registers, the handshake and the counters.

## Test plan
- Defaults with SECDED. in_code=0xFFFF, then 0x0000 → out_data=0x7FF then 0x000, both clean, syndrome 0, latency 2.
- SECDED. in_code=0x0004 (data[0] flipped) → out_data=0x000, syndrome=3, corrected=1, corr_cnt=1.
- SECDED. in_code=0x0003 (positions 1 and 2 flipped) → syndrome=3, uncorrectable=1, out_data=0x000, uncorr_cnt=1.
- SECDED. in_code=0x8000 (only overall parity flipped) → syndrome=0, corrected=1, out_data=0x000.
- Backpressure: 4 back-to-back words, out_ready=0 for 3 cycles → in_ready drops after 2 accepted; all 4 delivered in order with outputs stable while stalled.
- CNT_W=2: 5 single-error words → corr_cnt=3. Then clr_cnt coincident with a sixth error → corr_cnt=0. Assert rst_n=0 with both stages full → out_valid=0 the next cycle and nothing is emitted.
